// File: rtl/seq_adder.sv
// seq_adder: bit-serial 8-bit adder (in: clk, rst, A, B; out: sum, cr_out, done), one LOAD edge then eight ADD edges
module seq_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] sum,
  output logic       cr_out,
  output logic       done
);
  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DN   = 2'd2;
  logic [1:0] state;
  logic [7:0] A1, B1;
  logic [3:0] bit_count;
  logic       a_k, b_k;
  always_comb begin
    a_k = A1[bit_count[2:0]];
    b_k = B1[bit_count[2:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      A1        <= '0;
      B1        <= '0;
      bit_count <= '0;
      sum       <= '0;
      cr_out    <= 1'b0;
      done      <= 1'b0;
    end else if (state == LOAD) begin
      A1        <= A;
      B1        <= B;
      bit_count <= '0;
      sum       <= '0;
      cr_out    <= 1'b0;
      done      <= 1'b0;
      state     <= ADD;
    end else if (state == ADD) begin
      sum[bit_count[2:0]] <= a_k ^ b_k ^ cr_out;
      cr_out    <= (a_k & b_k) | (a_k & cr_out) | (b_k & cr_out);
      bit_count <= bit_count + 4'd1;
      done      <= bit_count == 4'd7;
      state     <= bit_count == 4'd7 ? DN : ADD;
    end
  end
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: randomized and directed scoreboard bench for seq_adder
module tb_seq_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] sum;
  logic       cr_out;
  logic       done;
  int         errors = 0;
  int         checks = 0;
  logic [8:0] q[$];
  logic       done_q = 1'b0;
  seq_adder dut (.clk(clk), .rst(rst), .A(A), .B(B), .sum(sum), .cr_out(cr_out), .done(done));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("result", {23'd0, cr_out, sum}, {23'd0, q.pop_front()});
    end
    done_q = done;
  end
  task automatic op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit iso, input int abort_at);
    int s, k, mask;
    rst = 1'b1;
    repeat (hold) @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_cr", cr_out, 0);
    chk("reset_done", done, 0);
    chk("reset_bit_count", dut.bit_count, 0);
    A = a;
    B = b;
    rst = 1'b0;
    s = a + b;
    q.push_back(s[8:0]);
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (iso && e == 1) begin
        A = 8'hFF;
        B = 8'hFF;
      end
      k = e < 2 ? 0 : (e > 9 ? 8 : e - 1);
      mask = (1 << k) - 1;
      chk("done", done, e >= 9);
      chk("sum", sum, s & mask & 255);
      chk("carry", cr_out, (((a & mask) + (b & mask)) >> k) & 1);
      if (e == abort_at) begin
        rst = 1'b1;
        void'(q.pop_back());
        @(negedge clk);
        chk("abort_sum", sum, 0);
        chk("abort_cr", cr_out, 0);
        chk("abort_done", done, 0);
        chk("abort_bit_count", dut.bit_count, 0);
        return;
      end
    end
    chk("final_bit_count", dut.bit_count, 8);
  endtask
  initial begin
    op(8'h24, 8'h81, 2, 0, 0);
    op(8'hFF, 8'h01, 1, 0, 0);
    op(8'hFF, 8'hFF, 3, 0, 0);
    op(8'h0F, 8'h01, 1, 0, 0);
    op(8'h24, 8'h81, 1, 1, 0);
    op(8'h24, 8'h81, 1, 0, 5);
    op(8'h81, 8'h09, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      op(8'($urandom), 8'($urandom), int'($urandom_range(1, 3)), 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
